// File: rtl/memory_cell_arbiter_if.sv
// Request/grant bundle between the four memory users and the cell arbiter.
// The master side is the user population; the slave side is the arbiter.
interface memory_cell_arbiter_if;
    logic [3:0] request;
    logic [3:0] cellSelect;
    logic [3:0] broadcast;
    logic [1:0] cell0ToUser;
    logic [1:0] cell1ToUser;
    logic       cell0Busy;
    logic       cell1Busy;
    logic [3:0] grant;

    modport master (
        output request, cellSelect, broadcast,
        input  cell0ToUser, cell1ToUser, cell0Busy, cell1Busy, grant
    );

    modport slave (
        input  request, cellSelect, broadcast,
        output cell0ToUser, cell1ToUser, cell0Busy, cell1Busy, grant
    );
endinterface

// File: rtl/memory_cell_arbiter.sv
// Allocates the two RAM cells of the 2x4 crossbar to the four users.
// Each cell is arbitrated round-robin. A broadcast user can take both cells
// at once. A hold limit stops one owner from starving a waiting requester.
module memory_cell_arbiter #(
    parameter int maxHold  = 8,
    parameter int holdBits = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    memory_cell_arbiter_if.slave bus
);

    typedef enum logic {IDLE, OWNED} cellState_t;

    localparam logic [holdBits-1:0] holdLimit = holdBits'(maxHold);
    localparam logic                holdEnabled = (maxHold != 0);

    cellState_t          state0, state1;
    logic [1:0]          owner0, owner1;
    logic [1:0]          last0, last1;
    logic [holdBits-1:0] count0, count1;
    logic [3:0]          grantReg;

    cellState_t          state0Next, state1Next;
    logic [1:0]          owner0Next, owner1Next;
    logic [1:0]          last0Next, last1Next;
    logic [holdBits-1:0] count0Next, count1Next;
    logic [3:0]          grantNext;

    logic [3:0] elig0, elig1;
    logic       expire0, expire1;
    logic       keep0, keep1;
    logic [3:0] excl0, excl1;
    logic [3:0] bcCand, single0, single1;
    logic       anyBc;
    logic       grab0, grab1;
    logic [1:0] win0, win1;
    logic [2:0] pick0, pick1, pickBc;

    // Round-robin search: first set bit of cand starting at last+1, wrapping mod 4.
    // Result is {found, index}.
    function automatic logic [2:0] rrPick(input logic [3:0] cand, input logic [1:0] last);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!result[2] && cand[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    function automatic logic [3:0] oneHot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Eligibility, keep/expiry decisions and reservations for this edge.
    always_comb begin
        elig0 = bus.request & (bus.broadcast | ~bus.cellSelect);
        elig1 = bus.request & (bus.broadcast | bus.cellSelect);

        expire0 = holdEnabled && (state0 == OWNED) && (count0 == holdLimit)
                  && |(elig0 & ~oneHot(owner0));
        expire1 = holdEnabled && (state1 == OWNED) && (count1 == holdLimit)
                  && |(elig1 & ~oneHot(owner1));

        keep0 = (state0 == OWNED) && elig0[owner0] && !expire0;
        keep1 = (state1 == OWNED) && elig1[owner1] && !expire1;

        excl0 = expire0 ? oneHot(owner0) : 4'b0000;
        excl1 = expire1 ? oneHot(owner1) : 4'b0000;

        bcCand  = bus.request & bus.broadcast & ~excl0 & ~excl1;
        single0 = elig0 & ~bus.broadcast & ~excl0;
        single1 = elig1 & ~bus.broadcast & ~excl1;
        anyBc   = |bcCand;

        pickBc = rrPick(bcCand, last0);
        pick0  = rrPick(single0, last0);
        pick1  = rrPick(single1, last1);
    end

    // Decide which free cells are granted and to whom. Free cells are held back
    // for a waiting broadcaster; a broadcaster already owning one cell may
    // complete its pair when the other cell frees up.
    always_comb begin
        grab0 = 1'b0;
        grab1 = 1'b0;
        win0  = 2'd0;
        win1  = 2'd0;
        if (!keep0 && !keep1) begin
            if (anyBc) begin
                grab0 = 1'b1;
                grab1 = 1'b1;
                win0  = pickBc[1:0];
                win1  = pickBc[1:0];
            end else begin
                grab0 = pick0[2];
                win0  = pick0[1:0];
                grab1 = pick1[2];
                win1  = pick1[1:0];
            end
        end else if (!keep0) begin
            if (anyBc) begin
                grab0 = bcCand[owner1];
                win0  = owner1;
            end else begin
                grab0 = pick0[2];
                win0  = pick0[1:0];
            end
        end else if (!keep1) begin
            if (anyBc) begin
                grab1 = bcCand[owner0];
                win1  = owner0;
            end else begin
                grab1 = pick1[2];
                win1  = pick1[1:0];
            end
        end
    end

    // Next cell state plus the grant vector that will be visible after the edge.
    always_comb begin
        state0Next = state0;
        owner0Next = owner0;
        last0Next  = last0;
        count0Next = count0;
        if (keep0) begin
            if (count0 < holdLimit) count0Next = count0 + 1'b1;
        end else if (grab0) begin
            state0Next = OWNED;
            owner0Next = win0;
            last0Next  = win0;
            count0Next = '0;
        end else begin
            state0Next = IDLE;
            count0Next = '0;
        end

        state1Next = state1;
        owner1Next = owner1;
        last1Next  = last1;
        count1Next = count1;
        if (keep1) begin
            if (count1 < holdLimit) count1Next = count1 + 1'b1;
        end else if (grab1) begin
            state1Next = OWNED;
            owner1Next = win1;
            last1Next  = win1;
            count1Next = '0;
        end else begin
            state1Next = IDLE;
            count1Next = '0;
        end

        grantNext = 4'b0000;
        for (int u = 0; u < 4; u++) begin
            if (bus.request[u]) begin
                if (bus.broadcast[u]) begin
                    grantNext[u] = (state0Next == OWNED) && (owner0Next == 2'(u))
                                && (state1Next == OWNED) && (owner1Next == 2'(u));
                end else if (bus.cellSelect[u]) begin
                    grantNext[u] = (state1Next == OWNED) && (owner1Next == 2'(u));
                end else begin
                    grantNext[u] = (state0Next == OWNED) && (owner0Next == 2'(u));
                end
            end
        end
    end

    // Cell state registers; reset leaves both cells idle with user 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0   <= IDLE;
            state1   <= IDLE;
            owner0   <= 2'd0;
            owner1   <= 2'd1;
            last0    <= 2'd3;
            last1    <= 2'd3;
            count0   <= '0;
            count1   <= '0;
            grantReg <= 4'b0000;
        end else begin
            state0   <= state0Next;
            state1   <= state1Next;
            owner0   <= owner0Next;
            owner1   <= owner1Next;
            last0    <= last0Next;
            last1    <= last1Next;
            count0   <= count0Next;
            count1   <= count1Next;
            grantReg <= grantNext;
        end
    end

    assign bus.cell0ToUser = owner0;
    assign bus.cell1ToUser = owner1;
    assign bus.cell0Busy   = (state0 == OWNED);
    assign bus.cell1Busy   = (state1 == OWNED);
    assign bus.grant       = grantReg;

endmodule
